// File: rtl/dma_pkg.sv
// Shared types and address-region constants for the DMA bus arbiter.
package dma_pkg;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_OAM  = 2'd1,
    OWN_HDMA = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [15:0] VRAM_LO  = 16'h8000;
  localparam logic [15:0] VRAM_HI  = 16'h9FFF;
  localparam logic [15:0] ECHO_LO  = 16'hE000;
  localparam logic [15:0] ECHO_OFS = 16'h2000;
  localparam logic [15:0] IO_LO    = 16'hFF00;
  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [7:0]  OAM_LAST = 8'h9F;

endpackage

// File: rtl/dma_addr_map.sv
// Combinational region decode: DMA source classification/echo remap and CPU HRAM/IO detect.
module dma_addr_map
  import dma_pkg::*;
(
  input  logic [15:0] src_addr,
  input  logic [15:0] cpu_addr,
  output logic        is_vram,
  output logic        is_echo,
  output logic        is_hram_io,
  output logic [15:0] remap
);

  assign is_vram    = (src_addr >= VRAM_LO) && (src_addr <= VRAM_HI);
  assign is_echo    = (src_addr >= ECHO_LO);
  assign remap      = is_echo ? (src_addr - ECHO_OFS) : src_addr;
  // FF80 and up is HRAM/IE; FF00-FF7F is the IO page
  assign is_hram_io = (cpu_addr >= HRAM_LO) || (cpu_addr[15:7] == IO_LO[15:7]);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the memory bus and VRAM/OAM write ports between the CPU, OAM DMA and HDMA;
// each DMA byte is a read phase then a write phase, ownership changes only at byte boundaries.
module dma_bus_arbiter
  import dma_pkg::*;
#(
  parameter int HDMA_GAP   = 0,
  parameter bit HDMA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_stall,
  input  logic        hdma_req,
  input  logic [15:0] hdma_src,
  input  logic [15:0] hdma_dst,
  output logic        hdma_ack,
  input  logic        oam_req,
  input  logic [15:0] oam_src,
  output logic        oam_ack,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic [1:0]  owner
);

  localparam logic [1:0] GAP_LAST = 2'(HDMA_GAP - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [1:0]  gap_q, gap_d;
  logic [15:0] addr_q;
  logic [12:0] dst_q;
  logic [7:0]  oam_idx_q;
  logic        blocked_q;
  logic [7:0]  data_q;

  logic        pick_hdma, pick_oam, arb, grant_hdma, grant_oam;
  logic [15:0] src_mux, src_remap;
  logic        src_vram, src_echo, cpu_hi_io;
  logic [7:0]  wr_data, wr_mux;
  logic        cpu_pass, is_wr, hdma_wr, oam_wr;
  logic        unused_dst;

  assign unused_dst = ^hdma_dst[15:13];

  // Simultaneous requests: fresh from IDLE the parameter decides, otherwise alternate
  always_comb begin
    pick_hdma = hdma_req;
    if (hdma_req && oam_req) begin
      if (state_q == IDLE) pick_hdma = HDMA_FIRST;
      else                 pick_hdma = (owner_q != OWN_HDMA);
    end
    pick_oam = oam_req && !pick_hdma;
  end

  assign src_mux = pick_hdma ? hdma_src : oam_src;

  dma_addr_map u_addr_map (
    .src_addr   (src_mux),
    .cpu_addr   (cpu_addr),
    .is_vram    (src_vram),
    .is_echo    (src_echo),
    .is_hram_io (cpu_hi_io),
    .remap      (src_remap)
  );

  // The IDLE decision is also taken at the end of WR/GAP so back-to-back bytes need no idle cycle
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gap_d      = gap_q;
    arb        = 1'b0;
    grant_hdma = 1'b0;
    grant_oam  = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      RD:   state_d = WR;
      WR: begin
        if (owner_q == OWN_HDMA && HDMA_GAP > 0) begin
          state_d = GAP;
          gap_d   = 2'd0;
        end else begin
          arb = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) arb = 1'b1;
        else                   gap_d = 2'(gap_q + 2'd1);
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (pick_hdma) begin
        state_d    = RD;
        owner_d    = OWN_HDMA;
        grant_hdma = 1'b1;
      end else if (pick_oam) begin
        state_d    = RD;
        owner_d    = OWN_OAM;
        grant_oam  = 1'b1;
      end else begin
        state_d    = IDLE;
        owner_d    = OWN_CPU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CPU;
      gap_q     <= 2'd0;
      addr_q    <= 16'h0000;
      dst_q     <= 13'h0000;
      oam_idx_q <= 8'h00;
      blocked_q <= 1'b0;
      data_q    <= 8'h00;
    end else if (ce) begin
      state_q <= state_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
      if (grant_hdma || grant_oam) addr_q <= src_remap;
      if (grant_hdma) begin
        dst_q     <= hdma_dst[12:0];
        blocked_q <= src_vram || src_echo;
      end
      if (grant_oam) begin
        oam_idx_q <= oam_src[7:0];
        blocked_q <= 1'b0;
      end
      if (state_q == WR) data_q <= wr_data;
    end
  end

  assign wr_data = blocked_q ? 8'hFF : bus_di;
  assign wr_mux  = (state_q == WR) ? wr_data : data_q;
  // A DMA read phase always owns the bus; the CPU only gets HRAM/IO through outside it
  assign cpu_pass = (state_q != RD) &&
                    ((owner_q == OWN_CPU) || (owner_q == OWN_OAM && cpu_hi_io));
  assign is_wr   = ce && (state_q == WR);
  assign hdma_wr = is_wr && (owner_q == OWN_HDMA);
  assign oam_wr  = is_wr && (owner_q == OWN_OAM);

  always_comb begin
    bus_addr  = (state_q == RD || !cpu_pass) ? addr_q : cpu_addr;
    bus_rd    = ce && (((state_q == RD) && !blocked_q) || (cpu_pass && cpu_rd));
    bus_wr    = ce && cpu_pass && cpu_wr;
    bus_do    = cpu_do;
    cpu_di    = cpu_pass ? bus_di : 8'hFF;
    cpu_stall = (owner_q == OWN_HDMA);
    hdma_ack  = hdma_wr;
    vram_we   = hdma_wr;
    vram_addr = dst_q;
    vram_data = wr_mux;
    oam_ack   = oam_wr;
    oam_we    = oam_wr && (oam_idx_q <= OAM_LAST);
    oam_addr  = oam_idx_q;
    oam_data  = wr_mux;
    owner     = owner_q;
    // Reset takes effect on the outputs immediately so an in-flight byte is dropped
    if (reset) begin
      bus_addr  = 16'h0000;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      bus_do    = 8'h00;
      cpu_di    = 8'hFF;
      cpu_stall = 1'b0;
      hdma_ack  = 1'b0;
      vram_we   = 1'b0;
      vram_addr = 13'h0000;
      vram_data = 8'h00;
      oam_ack   = 1'b0;
      oam_we    = 1'b0;
      oam_addr  = 8'h00;
      oam_data  = 8'h00;
      owner     = 2'd0;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter (one instance with HDMA_GAP=0, one with 2).
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [15:0] cpu_addr, hdma_src, hdma_dst, oam_src;
  logic        cpu_rd, cpu_wr, hdma_req, oam_req;
  logic [7:0]  cpu_do, bus_di;

  logic [7:0]  cpu_di, bus_do, vram_data, oam_addr, oam_data;
  logic        cpu_stall, hdma_ack, oam_ack, bus_rd, bus_wr, vram_we, oam_we;
  logic [15:0] bus_addr;
  logic [12:0] vram_addr;
  logic [1:0]  owner;

  logic [7:0]  g_cpu_di, g_bus_do, g_vram_data, g_oam_addr, g_oam_data;
  logic        g_cpu_stall, g_hdma_ack, g_oam_ack, g_bus_rd, g_bus_wr, g_vram_we, g_oam_we;
  logic [15:0] g_bus_addr;
  logic [12:0] g_vram_addr;
  logic [1:0]  g_owner;

  int checks = 0;
  int errors = 0;
  logic use_g;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.HDMA_GAP(0), .HDMA_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_stall(cpu_stall),
    .hdma_req(hdma_req), .hdma_src(hdma_src), .hdma_dst(hdma_dst), .hdma_ack(hdma_ack),
    .oam_req(oam_req), .oam_src(oam_src), .oam_ack(oam_ack),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_do(bus_do), .bus_di(bus_di),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_data(oam_data), .owner(owner)
  );

  dma_bus_arbiter #(.HDMA_GAP(2), .HDMA_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_do(cpu_do),
    .cpu_di(g_cpu_di), .cpu_stall(g_cpu_stall),
    .hdma_req(hdma_req), .hdma_src(hdma_src), .hdma_dst(hdma_dst), .hdma_ack(g_hdma_ack),
    .oam_req(oam_req), .oam_src(oam_src), .oam_ack(g_oam_ack),
    .bus_addr(g_bus_addr), .bus_rd(g_bus_rd), .bus_wr(g_bus_wr), .bus_do(g_bus_do), .bus_di(bus_di),
    .vram_we(g_vram_we), .vram_addr(g_vram_addr), .vram_data(g_vram_data),
    .oam_we(g_oam_we), .oam_addr(g_oam_addr), .oam_data(g_oam_data), .owner(g_owner)
  );

  logic        s_ack, s_we, s_stall, s_rd;
  logic [12:0] s_vaddr;
  logic [7:0]  s_vdata;
  logic [15:0] s_baddr;
  logic [1:0]  s_owner;
  assign s_ack   = use_g ? g_hdma_ack  : hdma_ack;
  assign s_we    = use_g ? g_vram_we   : vram_we;
  assign s_stall = use_g ? g_cpu_stall : cpu_stall;
  assign s_rd    = use_g ? g_bus_rd    : bus_rd;
  assign s_vaddr = use_g ? g_vram_addr : vram_addr;
  assign s_vdata = use_g ? g_vram_data : vram_data;
  assign s_baddr = use_g ? g_bus_addr  : bus_addr;
  assign s_owner = use_g ? g_owner     : owner;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; use_g = 1'b0;
    cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_do = 8'h00;
    hdma_req = 1'b0; hdma_src = 16'h0000; hdma_dst = 16'h0000;
    oam_req = 1'b0; oam_src = 16'h0000; bus_di = 8'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1; cpu_addr = 16'h1234; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_do = 8'hAB;
    tick();
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %h exp 0", owner); end
    checks++; if ({bus_rd, bus_wr, vram_we, oam_we, hdma_ack, oam_ack, cpu_stall} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000000", {bus_rd, bus_wr, vram_we, oam_we, hdma_ack, oam_ack, cpu_stall}); end
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL reset_cpu_di got %h exp ff", cpu_di); end
    checks++; if ({bus_addr, bus_do, vram_addr, vram_data, oam_addr, oam_data} !== 61'b0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", bus_addr, bus_do, vram_addr, vram_data); end
    reset = 1'b0;
    #1;
    checks++; if (bus_addr !== 16'h1234 || bus_rd !== 1'b1) begin
      errors++; $display("FAIL idle_passthrough got %h rd=%b exp 1234 rd=1", bus_addr, bus_rd); end
  endtask

  task automatic test_hdma(input bit g, input int gap);
    int interval, last, k;
    logic exp_ack, exp_rd, exp_stall;
    interval = 2 + gap;
    last = 2 + 3 * interval;
    k = 0;
    do_reset();
    use_g = g;
    hdma_src = 16'hC000; hdma_dst = 16'h8800; hdma_req = 1'b1;
    for (int c = 1; c <= last + gap + 1; c++) begin
      tick();
      exp_ack   = (k < 4) && (c == 2 + k * interval);
      exp_rd    = (k < 4) && (c == 1 + k * interval);
      exp_stall = (c <= last + gap);
      checks++; if (s_ack !== exp_ack || s_we !== exp_ack) begin
        errors++; $display("FAIL hdma_ack gap=%0d cyc=%0d got ack=%b we=%b exp %b", gap, c, s_ack, s_we, exp_ack); end
      checks++; if (s_stall !== exp_stall) begin
        errors++; $display("FAIL hdma_stall gap=%0d cyc=%0d got %b exp %b", gap, c, s_stall, exp_stall); end
      checks++; if (s_owner !== (exp_stall ? 2'd2 : 2'd0)) begin
        errors++; $display("FAIL hdma_owner gap=%0d cyc=%0d got %h exp %h", gap, c, s_owner, exp_stall ? 2'd2 : 2'd0); end
      checks++; if (s_rd !== exp_rd) begin
        errors++; $display("FAIL hdma_bus_rd gap=%0d cyc=%0d got %b exp %b", gap, c, s_rd, exp_rd); end
      if (exp_rd) begin
        checks++; if (s_baddr !== 16'hC000 + 16'(k)) begin
          errors++; $display("FAIL hdma_src gap=%0d got %h exp %h", gap, s_baddr, 16'hC000 + 16'(k)); end
        bus_di = 8'(8'h11 * (k + 1));
      end
      if (exp_ack) begin
        checks++; if (s_vaddr !== 13'h0800 + 13'(k) || s_vdata !== 8'(8'h11 * (k + 1))) begin
          errors++; $display("FAIL hdma_write gap=%0d got %h=%h exp %h=%h", gap, s_vaddr, s_vdata,
                             13'h0800 + 13'(k), 8'(8'h11 * (k + 1))); end
        k++;
        hdma_src = hdma_src + 16'd1;
        hdma_dst = hdma_dst + 16'd1;
        if (k == 4) hdma_req = 1'b0;
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL hdma_count gap=%0d got %0d exp 4", gap, k); end
  endtask

  task automatic test_arbitration();
    do_reset();
    hdma_src = 16'hC000; hdma_dst = 16'h8000; oam_src = 16'hE100;
    hdma_req = 1'b1; oam_req = 1'b1;
    tick();
    checks++; if (owner !== 2'd2 || bus_addr !== 16'hC000) begin
      errors++; $display("FAIL arb_first got owner=%h addr=%h exp 2 c000", owner, bus_addr); end
    bus_di = 8'h77;
    tick();
    checks++; if (hdma_ack !== 1'b1 || oam_ack !== 1'b0 || vram_data !== 8'h77) begin
      errors++; $display("FAIL arb_hdma_byte got ack=%b oack=%b d=%h exp 1 0 77", hdma_ack, oam_ack, vram_data); end
    hdma_req = 1'b0;
    tick();
    checks++; if (owner !== 2'd1 || bus_addr !== 16'hC100 || bus_rd !== 1'b1) begin
      errors++; $display("FAIL arb_oam_echo got owner=%h addr=%h rd=%b exp 1 c100 1", owner, bus_addr, bus_rd); end
    bus_di = 8'h88;
    tick();
    checks++; if (oam_ack !== 1'b1 || oam_we !== 1'b1 || oam_addr !== 8'h00 || oam_data !== 8'h88 || hdma_ack !== 1'b0) begin
      errors++; $display("FAIL arb_oam_byte got ack=%b we=%b %h=%h exp 1 1 00=88", oam_ack, oam_we, oam_addr, oam_data); end
    oam_src = 16'hE101;
    tick();
    checks++; if (bus_addr !== 16'hC101 || owner !== 2'd1) begin
      errors++; $display("FAIL arb_oam_next got %h owner=%h exp c101 1", bus_addr, owner); end
    bus_di = 8'h99;
    tick();
    checks++; if (oam_we !== 1'b1 || oam_addr !== 8'h01 || oam_data !== 8'h99) begin
      errors++; $display("FAIL arb_oam_byte2 got we=%b %h=%h exp 1 01=99", oam_we, oam_addr, oam_data); end
    oam_req = 1'b0;
    tick();
    checks++; if (owner !== 2'd0 || oam_ack !== 1'b0) begin
      errors++; $display("FAIL arb_release got owner=%h ack=%b exp 0 0", owner, oam_ack); end
  endtask

  task automatic test_cpu_during_oam();
    do_reset();
    oam_src = 16'hD000; oam_req = 1'b1;
    tick();
    cpu_rd = 1'b1; cpu_addr = 16'hC000; bus_di = 8'h12;
    #1;
    checks++; if (cpu_di !== 8'hFF || bus_addr !== 16'hD000 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL oam_cpu_rd_rdphase got di=%h addr=%h stall=%b exp ff d000 0", cpu_di, bus_addr, cpu_stall); end
    tick();
    #1;
    checks++; if (cpu_di !== 8'hFF || bus_rd !== 1'b0 || bus_wr !== 1'b0 || oam_ack !== 1'b1) begin
      errors++; $display("FAIL oam_cpu_rd_blocked got di=%h rd=%b wr=%b ack=%b exp ff 0 0 1", cpu_di, bus_rd, bus_wr, oam_ack); end
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hFF90; cpu_do = 8'h5A;
    #1;
    checks++; if (bus_wr !== 1'b1 || bus_addr !== 16'hFF90 || bus_do !== 8'h5A || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL oam_cpu_hram_wr got wr=%b %h=%h stall=%b exp 1 ff90=5a 0", bus_wr, bus_addr, bus_do, cpu_stall); end
    oam_req = 1'b0;
    tick();
    cpu_wr = 1'b0;
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL oam_cpu_release got %h exp 0", owner); end
  endtask

  task automatic test_blocked_sources();
    do_reset();
    hdma_src = 16'h8100; hdma_dst = 16'h9000; hdma_req = 1'b1;
    tick();
    checks++; if (bus_rd !== 1'b0 || owner !== 2'd2) begin
      errors++; $display("FAIL vram_src_rd got rd=%b owner=%h exp 0 2", bus_rd, owner); end
    bus_di = 8'h3C;
    tick();
    checks++; if (vram_we !== 1'b1 || vram_data !== 8'hFF || vram_addr !== 13'h1000) begin
      errors++; $display("FAIL vram_src_data got we=%b %h=%h exp 1 1000=ff", vram_we, vram_addr, vram_data); end
    hdma_req = 1'b0;
    do_reset();
    oam_src = 16'hC0A0; oam_req = 1'b1;
    tick();
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 16'hC0A0) begin
      errors++; $display("FAIL oam_a0_rd got rd=%b addr=%h exp 1 c0a0", bus_rd, bus_addr); end
    bus_di = 8'h55;
    tick();
    checks++; if (oam_ack !== 1'b1 || oam_we !== 1'b0) begin
      errors++; $display("FAIL oam_a0_write got ack=%b we=%b exp 1 0", oam_ack, oam_we); end
    oam_req = 1'b0;
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    hdma_src = 16'hC000; hdma_dst = 16'h8000; hdma_req = 1'b1;
    tick();
    bus_di = 8'h66;
    tick();
    checks++; if (hdma_ack !== 1'b1) begin errors++; $display("FAIL midrst_pre got ack=%b exp 1", hdma_ack); end
    reset = 1'b1;
    #1;
    checks++; if (hdma_ack !== 1'b0 || vram_we !== 1'b0 || vram_data !== 8'h00 || vram_addr !== 13'h0) begin
      errors++; $display("FAIL midrst_drop got ack=%b we=%b %h=%h exp 0 0 0=0", hdma_ack, vram_we, vram_addr, vram_data); end
    checks++; if (owner !== 2'd0 || cpu_stall !== 1'b0 || cpu_di !== 8'hFF || bus_rd !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got owner=%h stall=%b di=%h rd=%b exp 0 0 ff 0", owner, cpu_stall, cpu_di, bus_rd); end
    tick();
    reset = 1'b0; hdma_req = 1'b0;
    #1;
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL midrst_owner got %h exp 0", owner); end
    tick();
    checks++; if (hdma_ack !== 1'b0 || vram_we !== 1'b0) begin
      errors++; $display("FAIL midrst_after got ack=%b we=%b exp 0 0", hdma_ack, vram_we); end
  endtask

  task automatic test_clock_enable();
    do_reset();
    ce = 1'b0; hdma_src = 16'hC000; hdma_dst = 16'h8000; hdma_req = 1'b1;
    repeat (3) tick();
    checks++; if (owner !== 2'd0 || bus_rd !== 1'b0) begin
      errors++; $display("FAIL ce_frozen got owner=%h rd=%b exp 0 0", owner, bus_rd); end
    ce = 1'b1;
    tick();
    checks++; if (owner !== 2'd2 || bus_rd !== 1'b1) begin
      errors++; $display("FAIL ce_run got owner=%h rd=%b exp 2 1", owner, bus_rd); end
    tick();
    ce = 1'b0;
    #1;
    checks++; if (hdma_ack !== 1'b0 || vram_we !== 1'b0) begin
      errors++; $display("FAIL ce_gate got ack=%b we=%b exp 0 0", hdma_ack, vram_we); end
    hdma_req = 1'b0;
    tick();
    ce = 1'b1;
    #1;
    checks++; if (hdma_ack !== 1'b1) begin errors++; $display("FAIL ce_resume got ack=%b exp 1", hdma_ack); end
    tick();
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL ce_done got owner=%h exp 0", owner); end
  endtask

  initial begin
    test_reset();
    test_hdma(1'b0, 0);
    test_hdma(1'b1, 2);
    test_arbitration();
    test_cpu_during_oam();
    test_blocked_sources();
    test_reset_mid_byte();
    test_clock_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
